// File: rtl/csr_arbiter.sv
// csr_arbiter: serves core and debug CSR requests one at a time as read-modify-write
// transactions. Debug has priority, with a starvation guard that forces a core grant.
module csr_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_req_op,
  input  logic [11:0]       core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  input  logic              core_rsp_ready,
  output logic [DATA_W-1:0] core_rsp_rdata,

  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [1:0]        dbg_req_op,
  input  logic [11:0]       dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_rdata,

  output logic [11:0]       csr_addr,
  output logic              csr_wen,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic [DATA_W-1:0] csr_rdata
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);

  localparam logic [OP_W-1:0] OP_READ = 2'b00;
  localparam logic [OP_W-1:0] OP_RW   = 2'b01;
  localparam logic [OP_W-1:0] OP_RS   = 2'b10;
  localparam logic [OP_W-1:0] OP_RC   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                owner_dbg_q;
  logic [DATA_W-1:0]   old_q;
  logic [DATA_W-1:0]   new_q;
  logic [CNT_W-1:0]    starve_cnt_q;

  logic                grant_core;
  logic                grant_dbg;
  logic                force_core;
  logic                need_write;
  logic [DATA_W-1:0]   mod_data;

  // Core has waited through STARVE_MAX debug grants: it must win this time.
  assign force_core = core_req_valid && (starve_cnt_q == CNT_W'(STARVE_MAX));

  // RS/RC with a zero operand leave the CSR untouched, so they skip the write cycle.
  assign need_write = (op_q == OP_RW) ||
                      (((op_q == OP_RS) || (op_q == OP_RC)) && (wdata_q != '0));

  // Modified value computed from the live CSR read data during READ.
  always_comb begin
    mod_data = csr_rdata;
    case (op_q)
      OP_RW:   mod_data = wdata_q;
      OP_RS:   mod_data = csr_rdata | wdata_q;
      OP_RC:   mod_data = csr_rdata & ~wdata_q;
      default: mod_data = csr_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, arbitration and output decode.
  always_comb begin
    state_d        = state_q;
    grant_core     = 1'b0;
    grant_dbg      = 1'b0;
    core_req_ready = 1'b0;
    dbg_req_ready  = 1'b0;
    core_rsp_valid = 1'b0;
    dbg_rsp_valid  = 1'b0;
    core_rsp_rdata = '0;
    dbg_rsp_rdata  = '0;
    csr_addr       = '0;
    csr_wen        = 1'b0;
    csr_wdata      = '0;
    case (state_q)
      S_IDLE: begin
        if (!reset) begin
          if (dbg_req_valid && !force_core) begin
            grant_dbg = 1'b1;
          end else if (core_req_valid) begin
            grant_core = 1'b1;
          end
        end
        core_req_ready = grant_core;
        dbg_req_ready  = grant_dbg;
        if (grant_core || grant_dbg) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        csr_addr = addr_q;
        state_d  = need_write ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        csr_addr  = addr_q;
        csr_wen   = 1'b1;
        csr_wdata = new_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        csr_addr = addr_q;
        if (owner_dbg_q) begin
          dbg_rsp_valid = 1'b1;
          dbg_rsp_rdata = old_q;
          if (dbg_rsp_ready) begin
            state_d = S_IDLE;
          end
        end else begin
          core_rsp_valid = 1'b1;
          core_rsp_rdata = old_q;
          if (core_rsp_ready) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transaction latch on grant; old/new values captured in READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_dbg_q <= 1'b0;
      old_q       <= '0;
      new_q       <= '0;
    end else begin
      if (grant_dbg) begin
        op_q        <= dbg_req_op;
        addr_q      <= dbg_req_addr;
        wdata_q     <= dbg_req_wdata;
        owner_dbg_q <= 1'b1;
      end else if (grant_core) begin
        op_q        <= core_req_op;
        addr_q      <= core_req_addr;
        wdata_q     <= core_req_wdata;
        owner_dbg_q <= 1'b0;
      end
      if (state_q == S_READ) begin
        old_q <= csr_rdata;
        new_q <= mod_data;
      end
    end
  end

  // Counts debug grants that passed over a waiting core; any core grant clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else if (grant_core) begin
      starve_cnt_q <= '0;
    end else if (grant_dbg && core_req_valid && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
      starve_cnt_q <= starve_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: directed and randomized stimulus for csr_arbiter, with a transaction-level
// reference model and a response scoreboard in a negedge monitor.
module tb_csr_arbiter;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          TMO        = 300;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef struct packed {
    logic              owner;
    logic [DATA_W-1:0] old;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              core_req_valid, core_req_ready, core_rsp_valid, core_rsp_ready;
  logic [1:0]        core_req_op;
  logic [11:0]       core_req_addr;
  logic [DATA_W-1:0] core_req_wdata, core_rsp_rdata;
  logic              dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready;
  logic [1:0]        dbg_req_op;
  logic [11:0]       dbg_req_addr;
  logic [DATA_W-1:0] dbg_req_wdata, dbg_rsp_rdata;
  logic [11:0]       csr_addr;
  logic              csr_wen;
  logic [DATA_W-1:0] csr_wdata, csr_rdata;

  // CSR file seen by the DUT, and the reference model's own copy
  logic [DATA_W-1:0] csr_file  [0:4095] = '{default: '0};
  logic [DATA_W-1:0] model_mem [0:4095] = '{default: '0};

  int          cyc   = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        rand_on = 1'b0;

  // Reference model state
  logic              m_busy  = 1'b0;
  logic              m_owner = 1'b0;
  logic              m_write = 1'b0;
  logic              m_wpend = 1'b0;
  logic [11:0]       m_addr  = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int                m_wcyc  = 0;
  int                m_rcyc  = 0;
  int unsigned       m_starve = 0;
  exp_t              exp_q[$];
  logic              grant_log[$];

  csr_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clock          (clock),
    .reset          (reset),
    .core_req_valid (core_req_valid),
    .core_req_ready (core_req_ready),
    .core_req_op    (core_req_op),
    .core_req_addr  (core_req_addr),
    .core_req_wdata (core_req_wdata),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_ready (core_rsp_ready),
    .core_rsp_rdata (core_rsp_rdata),
    .dbg_req_valid  (dbg_req_valid),
    .dbg_req_ready  (dbg_req_ready),
    .dbg_req_op     (dbg_req_op),
    .dbg_req_addr   (dbg_req_addr),
    .dbg_req_wdata  (dbg_req_wdata),
    .dbg_rsp_valid  (dbg_rsp_valid),
    .dbg_rsp_ready  (dbg_rsp_ready),
    .dbg_rsp_rdata  (dbg_rsp_rdata),
    .csr_addr       (csr_addr),
    .csr_wen        (csr_wen),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // CSR file: combinational read, written on the DUT's write strobe
  assign csr_rdata = csr_file[csr_addr];
  always @(posedge clock) begin
    if (!reset && csr_wen) csr_file[csr_addr] <= csr_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: decides each grant, predicts timing, scores responses.
  task automatic monitor();
    logic              ec, ed, ewen, rdy, wr;
    logic [1:0]        op;
    logic [11:0]       a;
    logic [DATA_W-1:0] d, old, nv, rd;
    exp_t              e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_req_ready", 32'({core_req_ready, dbg_req_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({core_rsp_valid, dbg_rsp_valid}), 32'd0);
        chk("rst_csr_wen", 32'(csr_wen), 32'd0);
        chk("rst_csr_addr", 32'(csr_addr), 32'd0);
        chk("rst_csr_wdata", csr_wdata, 32'd0);
        chk("rst_rsp_rdata", core_rsp_rdata | dbg_rsp_rdata, 32'd0);
        m_busy = 1'b0; m_wpend = 1'b0; m_starve = 0;
        exp_q.delete();
      end else begin
        if (m_wpend && cyc > m_wcyc) begin
          model_mem[m_addr] = m_wdata;
          m_wpend = 1'b0;
        end
        ec = 1'b0; ed = 1'b0;
        if (!m_busy) begin
          if (dbg_req_valid && !(core_req_valid && m_starve >= STARVE_MAX)) ed = 1'b1;
          else if (core_req_valid) ec = 1'b1;
        end
        chk("core_req_ready", 32'(core_req_ready), 32'(ec));
        chk("dbg_req_ready", 32'(dbg_req_ready), 32'(ed));
        if (!m_busy) begin
          chk("idle_csr_addr", 32'(csr_addr), 32'd0);
          chk("idle_csr_wen", 32'(csr_wen), 32'd0);
          chk("idle_rsp_valid", 32'({core_rsp_valid, dbg_rsp_valid}), 32'd0);
          if (ec || ed) begin
            if (ed) begin
              op = dbg_req_op; a = dbg_req_addr; d = dbg_req_wdata;
              if (core_req_valid && m_starve < STARVE_MAX) m_starve++;
            end else begin
              op = core_req_op; a = core_req_addr; d = core_req_wdata;
              m_starve = 0;
            end
            old = model_mem[a];
            case (op)
              OP_RW:   nv = d;
              OP_RS:   nv = old | d;
              OP_RC:   nv = old & ~d;
              default: nv = old;
            endcase
            wr = (op == OP_RW) || (op != OP_READ && d != '0);
            m_busy = 1'b1; m_owner = ed; m_addr = a; m_write = wr; m_wdata = nv;
            m_wcyc = cyc + 2;
            m_rcyc = wr ? cyc + 3 : cyc + 2;
            e.owner = ed; e.old = old;
            exp_q.push_back(e);
            grant_log.push_back(ed);
          end
        end else begin
          ewen = m_write && (cyc == m_wcyc);
          chk("csr_addr", 32'(csr_addr), 32'(m_addr));
          chk("csr_wen", 32'(csr_wen), 32'(ewen));
          if (ewen) begin
            chk("csr_wdata", csr_wdata, m_wdata);
            m_wpend = 1'b1;
          end
          chk("core_rsp_valid", 32'(core_rsp_valid), 32'(!m_owner && cyc >= m_rcyc));
          chk("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(m_owner && cyc >= m_rcyc));
          if (cyc >= m_rcyc) begin
            rd  = m_owner ? dbg_rsp_rdata : core_rsp_rdata;
            rdy = m_owner ? dbg_rsp_ready : core_rsp_ready;
            n_chk++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL rsp_scoreboard: got response 0x%08h expected none queued", rd);
              m_busy = 1'b0;
            end else begin
              if (rd !== exp_q[0].old) begin
                n_err++;
                $display("FAIL rsp_rdata: got 0x%08h expected 0x%08h (cycle %0d)", rd, exp_q[0].old, cyc);
              end
              if (rdy) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
              end
            end
          end
        end
      end
    end
  endtask

  // Present one request on the chosen port and hold it until accepted.
  task automatic issue(input logic who, input logic [1:0] op, input logic [11:0] a,
                       input logic [DATA_W-1:0] d);
    int   t;
    logic rdy;
    t = 0;
    if (who) begin
      dbg_req_valid = 1'b1; dbg_req_op = op; dbg_req_addr = a; dbg_req_wdata = d;
    end else begin
      core_req_valid = 1'b1; core_req_op = op; core_req_addr = a; core_req_wdata = d;
    end
    @(negedge clock);
    rdy = who ? dbg_req_ready : core_req_ready;
    while (!rdy && t < TMO) begin
      @(negedge clock);
      rdy = who ? dbg_req_ready : core_req_ready;
      t++;
    end
    n_chk++;
    if (!rdy) begin
      n_err++;
      $display("FAIL accept_timeout_%s: ready 0 after %0d cycles, expected 1", who ? "dbg" : "core", TMO);
    end
    @(posedge clock); #1;
    if (who) dbg_req_valid = 1'b0;
    else     core_req_valid = 1'b0;
  endtask

  task automatic rand_issue(input logic who);
    logic [1:0]        op;
    logic [11:0]       a;
    logic [DATA_W-1:0] d;
    op = 2'($urandom_range(0, 3));
    a  = 12'h300 + 12'($urandom_range(0, 7));
    d  = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom());
    issue(who, op, a, d);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (m_busy && t < TMO);
    n_chk++;
    if (m_busy) begin
      n_err++;
      $display("FAIL idle_timeout: transaction still open after %0d cycles, expected done", TMO);
    end
  endtask

  initial begin
    int                n0;
    int                first_core;
    logic [DATA_W-1:0] saved;

    reset = 1'b1;
    core_req_valid = 1'b0; core_req_op = '0; core_req_addr = '0; core_req_wdata = '0;
    dbg_req_valid  = 1'b0; dbg_req_op  = '0; dbg_req_addr  = '0; dbg_req_wdata  = '0;
    core_rsp_ready = 1'b1; dbg_rsp_ready = 1'b1;

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Unmapped read returns 0; then set up 0x301 and do the RS/RC cases
    issue(1'b0, OP_READ, 12'h7FF, '0);                 wait_idle();
    issue(1'b0, OP_RW,   12'h301, 32'h4000_1000);      wait_idle();
    issue(1'b0, OP_RS,   12'h301, 32'h0000_0001);      wait_idle();
    chk("rs_csr_value", csr_file[12'h301], 32'h4000_1001);
    issue(1'b0, OP_RC,   12'h301, 32'h0);              wait_idle();
    chk("rc_zero_no_write", csr_file[12'h301], 32'h4000_1001);

    // Simultaneous requests: debug first, then core
    n0 = grant_log.size();
    fork
      issue(1'b0, OP_RC,   12'h301, 32'h0000_1000);
      issue(1'b1, OP_READ, 12'h301, '0);
    join
    wait_idle();
    chk("both_grant_count", 32'(grant_log.size()), 32'(n0 + 2));
    if (grant_log.size() >= n0 + 2) begin
      chk("both_first_dbg", 32'(grant_log[n0]), 32'd1);
      chk("both_second_core", 32'(grant_log[n0 + 1]), 32'd0);
    end
    chk("rc_csr_value", csr_file[12'h301], 32'h4000_0001);

    // Starvation: debug streams back to back while core waits
    n0 = grant_log.size();
    fork
      issue(1'b0, OP_RW, 12'h302, 32'hC0DE_0000);
      begin
        for (int k = 0; k < 6; k++) issue(1'b1, OP_RW, 12'h303, DATA_W'(k + 1));
      end
    join
    wait_idle();
    first_core = -1;
    for (int k = n0; k < grant_log.size(); k++) begin
      if (first_core < 0 && !grant_log[k]) first_core = k;
    end
    chk("starve_dbg_grants_before_core", 32'(first_core - n0), 32'(STARVE_MAX));

    // Counter cleared: debug wins a tie again
    n0 = grant_log.size();
    fork
      issue(1'b0, OP_READ, 12'h302, '0);
      issue(1'b1, OP_READ, 12'h303, '0);
    join
    wait_idle();
    chk("post_starve_count", 32'(grant_log.size()), 32'(n0 + 2));
    if (grant_log.size() >= n0 + 2) chk("post_starve_dbg_first", 32'(grant_log[n0]), 32'd1);

    // Response back-pressure with a competing debug request
    core_rsp_ready = 1'b0;
    fork
      issue(1'b0, OP_RS, 12'h304, 32'h0000_0010);
      begin repeat (3) @(posedge clock); #1; issue(1'b1, OP_READ, 12'h304, '0); end
      begin repeat (9) @(posedge clock); #1; core_rsp_ready = 1'b1; end
    join
    wait_idle();

    // Reset during the WRITE cycle aborts the transaction
    saved = csr_file[12'h305];
    issue(1'b0, OP_RW, 12'h305, 32'hDEAD_BEEF);
    @(posedge clock);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("rst_write_wen_drop", 32'(csr_wen), 32'd0);
    chk("rst_write_no_rsp", 32'(core_rsp_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_write_csr_kept", csr_file[12'h305], saved);
    issue(1'b0, OP_READ, 12'h305, '0);
    wait_idle();

    // Randomized traffic from both requesters with random response stalls
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clock); #1;
          core_rsp_ready = ($urandom_range(0, 3) != 0);
          dbg_rsp_ready  = ($urandom_range(0, 3) != 0);
        end
        core_rsp_ready = 1'b1;
        dbg_rsp_ready  = 1'b1;
      end
      begin
        fork
          begin
            for (int k = 0; k < 40; k++) begin
              repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
              rand_issue(1'b0);
            end
          end
          begin
            for (int k = 0; k < 40; k++) begin
              repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
              rand_issue(1'b1);
            end
          end
        join
        rand_on = 1'b0;
      end
    join
    wait_idle();
    repeat (3) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
